// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder built from one shared 4-bit adder stepped LSB nibble first,
// with a start/busy/done handshake and a registered carry between nibbles.

module fulladd4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c_in,
    output logic [3:0] o_sum,
    output logic       o_c_out
);
    assign {o_c_out, o_sum} = 5'(i_a) + 5'(i_b) + 5'(i_c_in);
endmodule

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4,
    parameter int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out
);
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    // state | meaning
    // IDLE  | waiting for start; result registers hold last result
    // RUN   | one nibble added per cycle, idx selects the slice
    // DONE  | one-cycle done pulse; a new start is accepted here too
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_op_a;
    logic [W-1:0]     r_op_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_sum;
    logic             r_c_out;
    logic             r_busy;
    logic             r_done;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_sum_nib;
    logic             w_carry_nib;
    logic             w_ready;

    assign w_a_nib = r_op_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib = r_op_b[{r_idx, 2'b00} +: 4];
    assign w_ready = (r_state == IDLE) || (r_state == DONE);

    fulladd4 u_fulladd4 (
        .i_a     (w_a_nib),
        .i_b     (w_b_nib),
        .i_c_in  (r_carry),
        .o_sum   (w_sum_nib),
        .o_c_out (w_carry_nib)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_sum_nib;
                    r_carry                    <= w_carry_nib;
                    if (r_idx == IDX_LAST) begin
                        r_c_out <= w_carry_nib;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE share the acceptance path so back-to-back starts need no gap
                    if (w_ready && start) begin
                        r_op_a  <= a;
                        r_op_b  <= b;
                        r_carry <= c_in;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign c_out = r_c_out;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (NIBBLES=4): arithmetic, latency,
// ignored starts during RUN, back-to-back starts, and reset mid-operation.

module tb_nibble_serial_add_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         c_in  = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        @(negedge clk);
        a     = ia;
        b     = ib;
        c_in  = ic;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges until done; lat is done's position, nbusy the busy cycles before it.
    task automatic wait_done(output int lat, output int nbusy);
        bit found;
        found = 0;
        lat   = 0;
        nbusy = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (done) found = 1;
            else if (busy) nbusy++;
        end
        chk("done_seen", 32'(found), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ic, input logic [W-1:0] exp_sum, input logic exp_c);
        int lat, nb;
        issue(ia, ib, ic);
        wait_done(lat, nb);
        chk({tag, "_lat"},   32'(lat), 32'd5);
        chk({tag, "_busy"},  32'(nb),  32'd4);
        chk({tag, "_sum"},   32'(sum), 32'(exp_sum));
        chk({tag, "_cout"},  32'(c_out), 32'(exp_c));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"},  32'(busy), 32'd0);
        chk({tag, "_hold"},  32'(sum), 32'(exp_sum));
    endtask

    initial begin
        int lat, nb, ndone, nbusy;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(c_out), 32'd0);
        reset = 1'b0;

        run_op("t1", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
        run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("t3a", 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1);
        run_op("t3b", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);

        // start held through RUN while operands change: must be ignored
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(lat, nb);
        chk("t4_lat",  32'(lat), 32'd2);
        chk("t4_sum",  32'(sum), 32'h2345);
        chk("t4_cout", 32'(c_out), 32'd0);
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) nbusy++;
        end
        chk("t4_extra_done", 32'(ndone), 32'd0);
        chk("t4_extra_busy", 32'(nbusy), 32'd0);

        // back-to-back: new start in the DONE cycle
        issue(16'h0003, 16'h0004, 1'b0);
        wait_done(lat, nb);
        chk("t5a_sum", 32'(sum), 32'h0007);
        a = 16'h0009; b = 16'h0009; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, nb);
        chk("t5_gap",  32'(lat), 32'd5);
        chk("t5_busy", 32'(nb),  32'd4);
        chk("t5_sum",  32'(sum), 32'h0012);
        chk("t5_cout", 32'(c_out), 32'd0);

        run_op("t6pre", 16'h8000, 16'h8001, 1'b0, 16'h0001, 1'b1);

        // reset two cycles into RUN
        issue(16'h1111, 16'h2222, 1'b0);
        repeat (3) @(negedge clk);
        chk("t6_mid_busy", 32'(busy), 32'd1);
        chk("t6_mid_sum",  32'(sum),  32'h0033);
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_sum",  32'(sum),  32'd0);
        chk("t6_rst_cout", 32'(c_out), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) nbusy++;
        end
        chk("t6_no_done", 32'(ndone), 32'd0);
        chk("t6_no_busy", 32'(nbusy), 32'd0);
        run_op("t6post", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
